// File: rtl/mode_select_controller_if.sv
// Signal bundle between the game screen timer / board buttons and mode_select_controller.
// master = timer and board side, slave = the controller.
interface mode_select_controller_if;
    logic       logo;
    logic       select_mode_screen;
    logic       end_of_game;
    logic       play_again;
    logic       btn_up;
    logic       btn_down;
    logic       btn_select;
    logic       btn_quit;
    logic       selected_a_mode;
    logic       two_player_mode;
    logic       end_game_early;
    logic       end_tutorial;
    logic [1:0] menu_cursor;
    logic [2:0] game_state;
    logic [2:0] tutorial_page;

    modport master (
        output logo, select_mode_screen, end_of_game, play_again,
        output btn_up, btn_down, btn_select, btn_quit,
        input  selected_a_mode, two_player_mode, end_game_early, end_tutorial,
        input  menu_cursor, game_state, tutorial_page
    );

    modport slave (
        input  logo, select_mode_screen, end_of_game, play_again,
        input  btn_up, btn_down, btn_select, btn_quit,
        output selected_a_mode, two_player_mode, end_game_early, end_tutorial,
        output menu_cursor, game_state, tutorial_page
    );
endinterface

// File: rtl/mode_select_controller.sv
// Menu/game FSM behind debounced buttons; a press acts DEBOUNCE_CYCLES+4 edges after the raw rise.
// No backpressure: events are single-cycle pulses, all outputs are registered.
module mode_select_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TUTORIAL_PAGES  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    mode_select_controller_if.slave  bus
);
    localparam int              CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      PAGE_LAST = 3'(TUTORIAL_PAGES - 1);
    localparam int              B_UP      = 0;
    localparam int              B_DN      = 1;
    localparam int              B_SEL     = 2;
    localparam int              B_QUIT    = 3;

    typedef enum logic [2:0] {
        S_LOGO     = 3'd0,
        S_SELECT   = 3'd1,
        S_TUTORIAL = 3'd2,
        S_PLAY1    = 3'd3,
        S_PLAY2    = 3'd4,
        S_SCORE    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    logic [3:0]          btn_raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          deb_q, deb_d, deb_prev_q, press_q;
    logic [3:0][CW-1:0]  cnt_q, cnt_d;

    state_t      state_q, state_d;
    logic [1:0]  cursor_q, cursor_d;
    logic [2:0]  page_q, page_d;
    logic        sel1_q, sel1_d;
    logic        sel2_q, sel2_d;
    logic        early_q, early_d;
    logic        endtut_q, endtut_d;

    logic up_ev, dn_ev, sel_ev, quit_ev;

    assign btn_raw = {bus.btn_quit, bus.btn_select, bus.btn_down, bus.btn_up};

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int b = 0; b < 4; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                deb_d[b] = ~deb_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            cnt_q      <= cnt_d;
        end
    end

    assign up_ev   = press_q[B_UP];
    assign dn_ev   = press_q[B_DN];
    assign sel_ev  = press_q[B_SEL];
    assign quit_ev = press_q[B_QUIT];

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        page_d   = page_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        early_d  = early_q;
        endtut_d = endtut_q;
        case (state_q)
            S_LOGO: begin
                if (bus.select_mode_screen) state_d = S_SELECT;
            end
            S_SELECT: begin
                // An accepted select uses the cursor as it stood before any same-cycle move.
                if (sel_ev && bus.select_mode_screen) begin
                    case (cursor_q)
                        2'd0: begin
                            sel1_d  = 1'b1;
                            sel2_d  = 1'b0;
                            state_d = S_PLAY1;
                        end
                        2'd1: begin
                            sel1_d  = 1'b0;
                            sel2_d  = 1'b1;
                            state_d = S_PLAY2;
                        end
                        default: begin
                            page_d  = '0;
                            state_d = S_TUTORIAL;
                        end
                    endcase
                end else if (up_ev && !dn_ev) begin
                    cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                end else if (dn_ev && !up_ev) begin
                    cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                end
            end
            S_TUTORIAL: begin
                if (bus.play_again) begin
                    state_d  = S_DONE;
                    early_d  = 1'b0;
                    endtut_d = 1'b0;
                end else if (!endtut_q) begin
                    if (quit_ev || (sel_ev && page_q == PAGE_LAST)) begin
                        endtut_d = 1'b1;
                    end else if (sel_ev) begin
                        page_d = page_q + 3'd1;
                    end
                end
            end
            S_PLAY1, S_PLAY2: begin
                if (bus.end_of_game) begin
                    state_d = S_SCORE;
                end else if (quit_ev) begin
                    early_d = 1'b1;
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                if (bus.play_again) begin
                    state_d  = S_DONE;
                    early_d  = 1'b0;
                    endtut_d = 1'b0;
                end
            end
            default: begin
                early_d  = 1'b0;
                endtut_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_LOGO;
            cursor_q <= '0;
            page_q   <= '0;
            sel1_q   <= 1'b0;
            sel2_q   <= 1'b0;
            early_q  <= 1'b0;
            endtut_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            page_q   <= page_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            early_q  <= early_d;
            endtut_q <= endtut_d;
        end
    end

    assign bus.selected_a_mode = sel1_q;
    assign bus.two_player_mode = sel2_q;
    assign bus.end_game_early  = early_q;
    assign bus.end_tutorial    = endtut_q;
    assign bus.menu_cursor     = cursor_q;
    assign bus.game_state      = state_q;
    assign bus.tutorial_page   = page_q;
endmodule

// File: tb/tb_mode_select_controller.sv
// Bench for mode_select_controller: directed scenarios plus randomized buttons/timer inputs
// against a behavioural model that tracks debounce as run lengths of raw samples.
module tb_mode_select_controller;
    localparam int D    = 4;
    localparam int P    = 4;
    localparam int UP   = 0;
    localparam int DN   = 1;
    localparam int SEL  = 2;
    localparam int QUIT = 3;
    localparam int M_LOGO = 0, M_SELECT = 1, M_TUT = 2, M_PLAY1 = 3, M_PLAY2 = 4, M_SCORE = 5, M_DONE = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn   = '0;
    logic       logo  = 1'b0;
    logic       sms   = 1'b0;
    logic       eog   = 1'b0;
    logic       pa    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    mode_select_controller_if bus();
    assign bus.logo               = logo;
    assign bus.select_mode_screen = sms;
    assign bus.end_of_game        = eog;
    assign bus.play_again         = pa;
    assign bus.btn_up             = btn[UP];
    assign bus.btn_down           = btn[DN];
    assign bus.btn_select         = btn[SEL];
    assign bus.btn_quit           = btn[QUIT];

    mode_select_controller #(.DEBOUNCE_CYCLES(D), .TUTORIAL_PAGES(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a button level changes after D consecutive raw samples that
    // disagree with it; a rising level is acted on by the FSM 4 edges after the last sample.
    int m_state, m_cursor, m_page, cyc;
    bit m_sel1, m_sel2, m_early, m_endtut;
    bit lvl[4];
    int run[4];
    int evq[4][$];
    bit ev[4];

    task automatic model_step();
        cyc++;
        if (reset) begin
            m_state = M_LOGO; m_cursor = 0; m_page = 0;
            m_sel1 = 0; m_sel2 = 0; m_early = 0; m_endtut = 0;
            for (int b = 0; b < 4; b++) begin
                lvl[b] = 0; run[b] = 0; evq[b].delete();
            end
            return;
        end
        for (int b = 0; b < 4; b++) begin
            ev[b] = 0;
            if (evq[b].size() != 0 && evq[b][0] == cyc) begin
                ev[b] = 1;
                void'(evq[b].pop_front());
            end
        end
        case (m_state)
            M_LOGO:   if (sms) m_state = M_SELECT;
            M_SELECT: begin
                if (ev[SEL] && sms) begin
                    if (m_cursor == 0)      begin m_sel1 = 1; m_state = M_PLAY1; end
                    else if (m_cursor == 1) begin m_sel2 = 1; m_state = M_PLAY2; end
                    else                    begin m_page = 0; m_state = M_TUT; end
                end else if (ev[UP] != ev[DN]) begin
                    m_cursor = ev[UP] ? (m_cursor + 2) % 3 : (m_cursor + 1) % 3;
                end
            end
            M_TUT: begin
                if (pa) begin
                    m_state = M_DONE; m_endtut = 0; m_early = 0;
                end else if (!m_endtut) begin
                    if (ev[QUIT]) m_endtut = 1;
                    else if (ev[SEL]) begin
                        if (m_page == P - 1) m_endtut = 1;
                        else m_page++;
                    end
                end
            end
            M_PLAY1, M_PLAY2: begin
                if (eog) m_state = M_SCORE;
                else if (ev[QUIT]) begin m_early = 1; m_state = M_SCORE; end
            end
            M_SCORE: if (pa) begin m_state = M_DONE; m_early = 0; m_endtut = 0; end
            default: ;
        endcase
        for (int b = 0; b < 4; b++) begin
            if (btn[b] != lvl[b]) begin
                run[b]++;
                if (run[b] == D) begin
                    lvl[b] = btn[b];
                    run[b] = 0;
                    if (btn[b]) evq[b].push_back(cyc + 4);
                end
            end else begin
                run[b] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("state",  bus.game_state,      m_state);
            check("cursor", bus.menu_cursor,     m_cursor);
            check("page",   bus.tutorial_page,   m_page);
            check("sel1",   bus.selected_a_mode, m_sel1);
            check("sel2",   bus.two_player_mode, m_sel2);
            check("early",  bus.end_game_early,  m_early);
            check("endtut", bus.end_tutorial,    m_endtut);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        btn = m;
        tick(hold);
        btn = '0;
        tick(D + 6);
    endtask

    task automatic restart();
        reset = 1'b1; pa = 1'b0; eog = 1'b0; sms = 1'b1; btn = '0;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    function automatic logic [3:0] flags();
        return {bus.selected_a_mode, bus.two_player_mode, bus.end_game_early, bus.end_tutorial};
    endfunction

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("rst_state", bus.game_state, 0);
        check("rst_flags", flags(), 4'b0000);
        reset = 1'b0;

        // Select held in LOGO is ignored.
        logo = 1'b1; btn[SEL] = 1'b1; tick(12); btn = '0; tick(10);
        check("logo_state", bus.game_state, M_LOGO);
        check("logo_flags", flags(), 4'b0000);
        logo = 1'b0; sms = 1'b1; tick(2);
        check("sel_entry", bus.game_state, M_SELECT);
        check("sel_cursor0", bus.menu_cursor, 0);

        // Raw rise right after edge n: cursor moves exactly at edge n+8.
        btn[DN] = 1'b1; tick(7);
        check("lat_edge7", bus.menu_cursor, 0);
        tick(1);
        check("lat_edge8", bus.menu_cursor, 1);
        tick(2); btn = '0; tick(10);

        sms = 1'b0; press(4'b0100, 8);
        check("nosms_state", bus.game_state, M_SELECT);
        check("nosms_flags", flags(), 4'b0000);
        sms = 1'b1;

        press(4'b0001, 6); check("up_to0", bus.menu_cursor, 0);
        press(4'b0001, 6); check("up_wrap", bus.menu_cursor, 2);
        press(4'b0011, 6); check("updn_same", bus.menu_cursor, 2);
        press(4'b0010, 3); check("glitch", bus.menu_cursor, 2);
        press(4'b0100, 6);
        check("tut_state", bus.game_state, M_TUT);
        check("tut_page0", bus.tutorial_page, 0);
        repeat (3) press(4'b0100, 6);
        check("tut_page3", bus.tutorial_page, 3);
        check("tut_notend", bus.end_tutorial, 0);
        press(4'b0100, 6);
        check("tut_end", bus.end_tutorial, 1);
        press(4'b0100, 6);
        check("tut_hold", bus.tutorial_page, 3);
        pa = 1'b1; tick(2);
        check("tut_done", bus.game_state, M_DONE);
        check("tut_done_end", bus.end_tutorial, 0);

        // Two-player: down then select.
        restart();
        press(4'b0010, 6); press(4'b0100, 6);
        check("p2_state", bus.game_state, M_PLAY2);
        check("p2_flags", flags(), 4'b0100);
        press(4'b1000, 6);
        check("p2_quit_state", bus.game_state, M_SCORE);
        tick(5);
        check("p2_early_held", bus.end_game_early, 1);
        pa = 1'b1; tick(2);
        check("p2_done", bus.game_state, M_DONE);
        check("p2_done_flags", flags(), 4'b0100);

        // Quit event lands on the same edge end_of_game is sampled.
        restart();
        press(4'b0100, 6);
        check("p1_state", bus.game_state, M_PLAY1);
        btn[QUIT] = 1'b1; tick(6); btn = '0; tick(1);
        eog = 1'b1; tick(1);
        check("eog_quit_state", bus.game_state, M_SCORE);
        check("eog_quit_early", bus.end_game_early, 0);
        eog = 1'b0; tick(10);

        // Reset in PLAY2 with select held through reset.
        restart();
        press(4'b0010, 6); press(4'b0100, 6);
        check("mid_p2", bus.game_state, M_PLAY2);
        btn[SEL] = 1'b1; tick(3);
        reset = 1'b1; tick(1);
        check("mid_rst_state", bus.game_state, M_LOGO);
        check("mid_rst_flags", flags(), 4'b0000);
        tick(1);
        reset = 1'b0; tick(6);
        check("held_noev_state", bus.game_state, M_SELECT);
        check("held_noev_sel1", bus.selected_a_mode, 0);
        tick(3);
        check("held_ev_state", bus.game_state, M_PLAY1);
        btn = '0; tick(10);

        // Randomized episodes.
        for (int ep = 0; ep < 8; ep++) begin
            restart();
            sms = 1'b0;
            for (int c = 0; c < 700; c++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
                if ($urandom_range(0, 19) == 0) sms = ~sms;
                eog = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 299) == 0) pa = 1'b1;
                reset = ($urandom_range(0, 499) == 0);
                if (reset) pa = 1'b0;
                tick(1);
            end
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
